// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Types and constants shared by the multi-cycle MIPS control path:
//   state_t        - sequencer state encoding (also decoded by control_signal)
//   instr_class_t  - coarse instruction class that steers the sequencer
//   OP_* / FN_*    - primary opcode (IR[31:26]) and SPECIAL funct (IR[5:0])
// Related build macro: MIPS_SEQ_WATCHDOG_EN (used by mips_state_sequencer).
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [2:0] {
      ST_FETCH         = 3'b000,
      ST_DECODE        = 3'b001,
      ST_EXECUTE       = 3'b010,
      ST_MEMORY_ACCESS = 3'b011,
      ST_WRITE_BACK    = 3'b100,
      ST_HALTED        = 3'b101
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU    = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_MULDIV = 3'd3,
      CLS_NOWB   = 3'd4,
      CLS_LINK   = 3'd5
   } instr_class_t;

   // primary opcodes
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LWL     = 6'h22;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_LWR     = 6'h26;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SWL     = 6'h2A;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] OP_SWR     = 6'h2E;

   // SPECIAL funct codes
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // States in which the Avalon bus can hold the sequencer.
   function automatic logic is_bus_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEMORY_ACCESS);
   endfunction

endpackage

// File: rtl/mips_instr_class.sv
// -----------------------------------------------------------------------------
// mips_instr_class
// Purely combinational classifier: opcode / func_code -> instr_class_t.
// Ports:
//   i_opcode    [5:0]  IR[31:26]
//   i_func_code [5:0]  IR[5:0], only meaningful when i_opcode == SPECIAL
//   o_class            instruction class
// Anything not recognised falls into CLS_NOWB so the sequencer simply
// returns to FETCH without a write-back.
// -----------------------------------------------------------------------------
module mips_instr_class
   import mips_pkg::*;
(
   input  logic [5:0]   i_opcode,
   input  logic [5:0]   i_func_code,
   output instr_class_t o_class
);

   always_comb begin
      o_class = CLS_NOWB;
      if (i_opcode == OP_SPECIAL) begin
         case (i_func_code)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR,
            FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO:
               o_class = CLS_ALU;
            FN_JALR:
               o_class = CLS_LINK;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
               o_class = CLS_MULDIV;
            default:
               o_class = CLS_NOWB;
         endcase
      end else begin
         case (i_opcode)
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
               o_class = CLS_ALU;
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR:
               o_class = CLS_LOAD;
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR:
               o_class = CLS_STORE;
            default:
               o_class = CLS_NOWB;
         endcase
      end
   end

endmodule

// File: rtl/mips_state_sequencer.sv
// -----------------------------------------------------------------------------
// mips_state_sequencer
// Multi-cycle FSM producing the state consumed by control_signal.
//
//   state            | meaning
//   -----------------+-----------------------------------------------------
//   FETCH      (000) | read instruction; held while waitrequest
//   DECODE     (001) | IR written, register read
//   EXECUTE    (010) | ALU / address calc; mult/div held while alu_busy
//   MEMORY_ACC (011) | load/store data phase; held while waitrequest
//   WRITE_BACK (100) | register file write
//   HALTED     (101) | PC reached 0 (or bus watchdog); left only by reset
//
// Parameters: MAX_WAIT (watchdog limit), STATE_W (o_state width).
// Ports:
//   i_clk, i_reset (sync, active-high)
//   i_opcode, i_func_code    instruction fields (valid from EXECUTE)
//   i_waitrequest            Avalon stall
//   i_alu_busy               mult/div unit busy
//   i_pc_is_zero             registered PC == 0
//   o_state                  current state
//   o_active                 low only in HALTED
//   o_stall                  registered: state was held last cycle
//   o_mem_enable             combinational MemRead/MemWrite gate
//   o_instr_retired          one-cycle pulse on the first FETCH after an
//                            instruction completes
//   o_bus_error              sticky watchdog flag
// Build macro: MIPS_SEQ_WATCHDOG_EN enables the waitrequest watchdog; without
// it no counter exists and o_bus_error is tied low.
// -----------------------------------------------------------------------------
module mips_state_sequencer
   import mips_pkg::*;
#(
   parameter int MAX_WAIT = 255,
   parameter int STATE_W  = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [5:0]         i_opcode,
   input  logic [5:0]         i_func_code,
   input  logic               i_waitrequest,
   input  logic               i_alu_busy,
   input  logic               i_pc_is_zero,
   output logic [STATE_W-1:0] o_state,
   output logic               o_active,
   output logic               o_stall,
   output logic               o_mem_enable,
   output logic               o_instr_retired,
   output logic               o_bus_error
);

   if (STATE_W < 3) begin : g_bad_state_w
      $error("mips_state_sequencer: STATE_W must be at least 3");
   end
   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("mips_state_sequencer: MAX_WAIT must be at least 1");
   end

   state_t       r_state;
   logic         r_active;
   logic         r_stall;
   logic         r_retired;
   instr_class_t w_class;
   logic         w_wd_trip;

   mips_instr_class u_instr_class (
      .i_opcode    (i_opcode),
      .i_func_code (i_func_code),
      .o_class     (w_class)
   );

`ifdef MIPS_SEQ_WATCHDOG_EN
   localparam int WAIT_W = (MAX_WAIT < 256) ? 8 : $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_bus_error;

   // The hold that would bring the count to MAX_WAIT is the one that trips.
   assign w_wd_trip = is_bus_state(r_state) && i_waitrequest &&
                      (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));
   assign o_bus_error = r_bus_error;
`else
   assign w_wd_trip   = 1'b0;
   assign o_bus_error = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_FETCH;
         r_active  <= 1'b1;
         r_stall   <= 1'b0;
         r_retired <= 1'b0;
`ifdef MIPS_SEQ_WATCHDOG_EN
         r_wait_cnt  <= '0;
         r_bus_error <= 1'b0;
`endif
      end else begin
         r_stall   <= 1'b0;
         r_retired <= 1'b0;
`ifdef MIPS_SEQ_WATCHDOG_EN
         // Cleared whenever the bus does not hold us; bumped below on a hold.
         r_wait_cnt <= '0;
         if (w_wd_trip) begin
            r_bus_error <= 1'b1;
         end
`endif
         case (r_state)
            ST_FETCH: begin
               if (i_pc_is_zero) begin
                  r_state  <= ST_HALTED;
                  r_active <= 1'b0;
               end else if (w_wd_trip) begin
                  r_state  <= ST_HALTED;
                  r_active <= 1'b0;
               end else if (i_waitrequest) begin
                  r_stall <= 1'b1;
`ifdef MIPS_SEQ_WATCHDOG_EN
                  r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
               end else begin
                  r_state <= ST_DECODE;
               end
            end

            ST_DECODE: begin
               r_state <= ST_EXECUTE;
            end

            ST_EXECUTE: begin
               case (w_class)
                  CLS_LOAD, CLS_STORE: begin
                     r_state <= ST_MEMORY_ACCESS;
                  end
                  CLS_ALU, CLS_LINK: begin
                     r_state <= ST_WRITE_BACK;
                  end
                  CLS_MULDIV: begin
                     if (i_alu_busy) begin
                        r_stall <= 1'b1;
                     end else begin
                        r_state   <= ST_FETCH;
                        r_retired <= 1'b1;
                     end
                  end
                  default: begin
                     r_state   <= ST_FETCH;
                     r_retired <= 1'b1;
                  end
               endcase
            end

            ST_MEMORY_ACCESS: begin
               if (w_wd_trip) begin
                  r_state  <= ST_HALTED;
                  r_active <= 1'b0;
               end else if (i_waitrequest) begin
                  r_stall <= 1'b1;
`ifdef MIPS_SEQ_WATCHDOG_EN
                  r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
               end else if (w_class == CLS_STORE) begin
                  r_state   <= ST_FETCH;
                  r_retired <= 1'b1;
               end else begin
                  r_state <= ST_WRITE_BACK;
               end
            end

            ST_WRITE_BACK: begin
               r_state   <= ST_FETCH;
               r_retired <= 1'b1;
            end

            ST_HALTED: begin
               r_state  <= ST_HALTED;
               r_active <= 1'b0;
            end

            default: begin
               r_state  <= ST_FETCH;
               r_active <= 1'b1;
            end
         endcase
      end
   end

   assign o_state         = STATE_W'(r_state);
   assign o_active        = r_active;
   assign o_stall         = r_stall;
   assign o_instr_retired = r_retired;
   assign o_mem_enable    = ((r_state == ST_FETCH) && !i_pc_is_zero) ||
                            (r_state == ST_MEMORY_ACCESS);

endmodule

// File: tb/tb_mips_state_sequencer.sv
module tb_mips_state_sequencer;

   localparam int TB_MAX_WAIT = 4;
   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2,
                          S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;
   localparam int K_WB = 0, K_LOAD = 1, K_STORE = 2, K_MULDIV = 3, K_NOWB = 4;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [5:0] i_opcode = '0;
   logic [5:0] i_func_code = '0;
   logic       i_waitrequest = 1'b0;
   logic       i_alu_busy = 1'b0;
   logic       i_pc_is_zero = 1'b0;
   logic [2:0] o_state;
   logic       o_active, o_stall, o_mem_enable, o_instr_retired, o_bus_error;

   always #5 i_clk = ~i_clk;

   mips_state_sequencer #(.MAX_WAIT(TB_MAX_WAIT), .STATE_W(3)) dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_opcode        (i_opcode),
      .i_func_code     (i_func_code),
      .i_waitrequest   (i_waitrequest),
      .i_alu_busy      (i_alu_busy),
      .i_pc_is_zero    (i_pc_is_zero),
      .o_state         (o_state),
      .o_active        (o_active),
      .o_stall         (o_stall),
      .o_mem_enable    (o_mem_enable),
      .o_instr_retired (o_instr_retired),
      .o_bus_error     (o_bus_error)
   );

   // One planned cycle: inputs to drive plus the expected state in that cycle
   // and the events it causes (hold / retire / bus error) seen next cycle.
   typedef struct {
      logic [2:0] st;
      logic       wr, busy, pz, rst;
      logic [5:0] op, fn;
      logic       hold, ret, berr;
   } cyc_t;

   typedef struct {
      logic [2:0] st;
      logic       stall, ret, active, memen, berr;
      int         idx;
   } exp_t;

   typedef struct {
      logic [5:0] op, fn;
      int         kind;
   } ins_t;

   cyc_t trace[$];
   exp_t sb[$];
   ins_t tbl[$];
   int   n_checks = 0;
   int   n_errs   = 0;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom_range(0, 63));
   endfunction

   task automatic add_ins(input logic [5:0] op, input logic [5:0] fn, input int kind);
      ins_t t;
      t.op = op; t.fn = fn; t.kind = kind;
      tbl.push_back(t);
   endtask

   task automatic add_cyc(input logic [2:0] st, input logic wr, input logic busy,
                          input logic pz, input logic [5:0] op, input logic [5:0] fn,
                          input logic hold, input logic ret, input logic berr);
      cyc_t c;
      c.st = st; c.wr = wr; c.busy = busy; c.pz = pz; c.rst = 1'b0;
      c.op = op; c.fn = fn; c.hold = hold; c.ret = ret; c.berr = berr;
      trace.push_back(c);
   endtask

   // Cycle-level trace of one instruction from the spec's sequencing rules.
   task automatic gen_instr(input ins_t t, input int fw, input int mw, input int bw);
      for (int i = 0; i < fw; i++) add_cyc(S_F, 1'b1, rb(), 1'b0, r6(), r6(), 1'b1, 1'b0, 1'b0);
      add_cyc(S_F, 1'b0, rb(), 1'b0, r6(), r6(), 1'b0, 1'b0, 1'b0);
      add_cyc(S_D, rb(), rb(), rb(), r6(), r6(), 1'b0, 1'b0, 1'b0);
      case (t.kind)
         K_WB: begin
            add_cyc(S_E, rb(), rb(), rb(), t.op, t.fn, 1'b0, 1'b0, 1'b0);
            add_cyc(S_W, rb(), rb(), rb(), t.op, t.fn, 1'b0, 1'b1, 1'b0);
         end
         K_LOAD, K_STORE: begin
            add_cyc(S_E, rb(), rb(), rb(), t.op, t.fn, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < mw; i++) add_cyc(S_M, 1'b1, rb(), rb(), t.op, t.fn, 1'b1, 1'b0, 1'b0);
            if (t.kind == K_LOAD) begin
               add_cyc(S_M, 1'b0, rb(), rb(), t.op, t.fn, 1'b0, 1'b0, 1'b0);
               add_cyc(S_W, rb(), rb(), rb(), t.op, t.fn, 1'b0, 1'b1, 1'b0);
            end else begin
               add_cyc(S_M, 1'b0, rb(), rb(), t.op, t.fn, 1'b0, 1'b1, 1'b0);
            end
         end
         K_MULDIV: begin
            for (int i = 0; i < bw; i++) add_cyc(S_E, rb(), 1'b1, rb(), t.op, t.fn, 1'b1, 1'b0, 1'b0);
            add_cyc(S_E, rb(), 1'b0, rb(), t.op, t.fn, 1'b0, 1'b1, 1'b0);
         end
         default: add_cyc(S_E, rb(), rb(), rb(), t.op, t.fn, 1'b0, 1'b1, 1'b0);
      endcase
   endtask

   task automatic gen_halt(input int n);
      add_cyc(S_F, rb(), rb(), 1'b1, r6(), r6(), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) add_cyc(S_H, rb(), rb(), rb(), r6(), r6(), 1'b0, 1'b0, 1'b0);
      trace[trace.size()-1].rst = 1'b1;
   endtask

   task automatic gen_abort(input ins_t t, input int fw, input int mw, input int bw,
                            input int at);
      int s, a;
      s = trace.size();
      gen_instr(t, fw, mw, bw);
      a = (at < 0) ? $urandom_range(s, trace.size() - 1) : s + at;
      trace[a].rst = 1'b1;
      while (trace.size() > a + 1) trace.delete(trace.size() - 1);
   endtask

   task automatic gen_stuck();
`ifdef MIPS_SEQ_WATCHDOG_EN
      for (int i = 0; i < TB_MAX_WAIT - 1; i++) add_cyc(S_F, 1'b1, rb(), 1'b0, r6(), r6(), 1'b1, 1'b0, 1'b0);
      add_cyc(S_F, 1'b1, rb(), 1'b0, r6(), r6(), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) add_cyc(S_H, rb(), rb(), rb(), r6(), r6(), 1'b0, 1'b0, 1'b0);
      trace[trace.size()-1].rst = 1'b1;
`else
      for (int i = 0; i < 300; i++) add_cyc(S_F, 1'b1, rb(), 1'b0, r6(), r6(), 1'b1, 1'b0, 1'b0);
`endif
   endtask

   task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, idx, got, exp);
      end
   endtask

   // Monitor: every cycle is an output observation.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state",         e.idx, 8'(o_state),         8'(e.st));
            chk("stall",         e.idx, 8'(o_stall),         8'(e.stall));
            chk("instr_retired", e.idx, 8'(o_instr_retired), 8'(e.ret));
            chk("active",        e.idx, 8'(o_active),        8'(e.active));
            chk("mem_enable",    e.idx, 8'(o_mem_enable),    8'(e.memen));
            chk("bus_error",     e.idx, 8'(o_bus_error),     8'(e.berr));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout checks=%0d", n_checks);
      $fatal(1, "simulation time limit");
   end

   // Stimulus / scoreboard push
   initial begin
      ins_t t;
      exp_t e;
      logic prev_hold, prev_ret, prev_berr, prev_rst, berr_exp;
      int   r;

      // spec-defined classes
      add_ins(6'h00, 6'h21, K_WB);  add_ins(6'h00, 6'h23, K_WB);
      add_ins(6'h00, 6'h24, K_WB);  add_ins(6'h00, 6'h25, K_WB);
      add_ins(6'h00, 6'h26, K_WB);  add_ins(6'h00, 6'h00, K_WB);
      add_ins(6'h00, 6'h02, K_WB);  add_ins(6'h00, 6'h03, K_WB);
      add_ins(6'h00, 6'h04, K_WB);  add_ins(6'h00, 6'h06, K_WB);
      add_ins(6'h00, 6'h07, K_WB);  add_ins(6'h00, 6'h2A, K_WB);
      add_ins(6'h00, 6'h2B, K_WB);  add_ins(6'h00, 6'h10, K_WB);
      add_ins(6'h00, 6'h12, K_WB);  add_ins(6'h00, 6'h09, K_WB);
      add_ins(6'h09, r6(), K_WB);   add_ins(6'h0A, r6(), K_WB);
      add_ins(6'h0B, r6(), K_WB);   add_ins(6'h0C, r6(), K_WB);
      add_ins(6'h0D, r6(), K_WB);   add_ins(6'h0E, r6(), K_WB);
      add_ins(6'h23, r6(), K_LOAD); add_ins(6'h20, r6(), K_LOAD);
      add_ins(6'h21, r6(), K_LOAD); add_ins(6'h24, r6(), K_LOAD);
      add_ins(6'h25, r6(), K_LOAD);
      add_ins(6'h2B, r6(), K_STORE); add_ins(6'h28, r6(), K_STORE);
      add_ins(6'h29, r6(), K_STORE);
      add_ins(6'h00, 6'h18, K_MULDIV); add_ins(6'h00, 6'h19, K_MULDIV);
      add_ins(6'h00, 6'h1A, K_MULDIV); add_ins(6'h00, 6'h1B, K_MULDIV);
      add_ins(6'h00, 6'h08, K_NOWB); add_ins(6'h00, 6'h11, K_NOWB);
      add_ins(6'h00, 6'h13, K_NOWB); add_ins(6'h04, r6(), K_NOWB);
      add_ins(6'h05, r6(), K_NOWB);  add_ins(6'h02, r6(), K_NOWB);
      add_ins(6'h00, 6'h0C, K_NOWB); add_ins(6'h3F, r6(), K_NOWB);

      // directed scenarios
      t.op = 6'h00; t.fn = 6'h21; t.kind = K_WB;     gen_instr(t, 0, 0, 0);
      t.op = 6'h23; t.fn = 6'h00; t.kind = K_LOAD;   gen_instr(t, 0, 3, 0);
      t.op = 6'h2B; t.fn = 6'h00; t.kind = K_STORE;  gen_instr(t, 2, 0, 0);
      t.op = 6'h00; t.fn = 6'h1B; t.kind = K_MULDIV; gen_instr(t, 0, 0, 32);
      t.op = 6'h00; t.fn = 6'h08; t.kind = K_NOWB;   gen_instr(t, 0, 0, 0);
      gen_halt(20);
      gen_stuck();
      t.op = 6'h00; t.fn = 6'h00; t.kind = K_WB;     gen_instr(t, 1, 0, 0);
      t.op = 6'h00; t.fn = 6'h1A; t.kind = K_MULDIV; gen_abort(t, 0, 0, 10, 7);
      t.op = 6'h23; t.fn = 6'h00; t.kind = K_LOAD;   gen_abort(t, 0, 3, 0, 4);

      // randomized program
      for (int k = 0; k < 150; k++) begin
         t = tbl[$urandom_range(0, tbl.size() - 1)];
         r = $urandom_range(0, 19);
         if (r == 0)
            gen_halt($urandom_range(1, 5));
         else if (r < 3)
            gen_abort(t, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6), -1);
         else
            gen_instr(t, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 3), $urandom_range(0, 6));
      end
      t.op = 6'h00; t.fn = 6'h25; t.kind = K_WB; gen_instr(t, 0, 0, 0);

      repeat (2) @(posedge i_clk);
      prev_hold = 1'b0; prev_ret = 1'b0; prev_berr = 1'b0; prev_rst = 1'b1; berr_exp = 1'b0;
      for (int k = 0; k < trace.size(); k++) begin
         @(posedge i_clk);
         #1;
         i_reset       = trace[k].rst;
         i_waitrequest = trace[k].wr;
         i_alu_busy    = trace[k].busy;
         i_pc_is_zero  = trace[k].pz;
         i_opcode      = trace[k].op;
         i_func_code   = trace[k].fn;
         e.idx    = k;
         e.st     = trace[k].st;
         e.stall  = prev_rst ? 1'b0 : prev_hold;
         e.ret    = prev_rst ? 1'b0 : prev_ret;
         berr_exp = prev_rst ? 1'b0 : (berr_exp | prev_berr);
         e.berr   = berr_exp;
         e.active = (trace[k].st != S_H);
         e.memen  = ((trace[k].st == S_F) && !trace[k].pz) || (trace[k].st == S_M);
         sb.push_back(e);
         prev_hold = trace[k].hold;
         prev_ret  = trace[k].ret;
         prev_berr = trace[k].berr;
         prev_rst  = trace[k].rst;
      end
      @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("scoreboard_drained", 0, 8'(sb.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
